switch_led_ctrl: RTL and testbench

- Parametrised successor to the direct switch-to-LED mapping.
- Synchronises and debounces a WIDTH-bit switch bank, then drives a WIDTH-bit LED bank in one of four display modes: pass-through, binary counter, chaser, blink.
- A free-running prescaler provides the step rate.
- Top-level board block: switches in, LEDs out.

---
 rtl/switch_led_ctrl.sv | 141 ++++++++++++++
 tb/tb_switch_led_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_led_ctrl.sv
// Board-level switch bank to LED bank controller: synchronise, debounce, then
// display the debounced switches as pass-through, binary counter, chaser or blink.

module switch_led_db_lane #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_s,
    output logic stable,
    output logic upd
);
    localparam int              DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;

    // Any return to the stable level wipes the count: no partial credit.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        upd      = 1'b0;
        if (sw_s != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = sw_s;
                upd      = 1'b1;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
endmodule

module switch_led_ctrl #(
    parameter int WIDTH    = 6,
    parameter int DEBOUNCE = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] sw_stable,
    output logic             changed
);
    localparam int              PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] sw_m_q, sw_s_q;
    logic [1:0]       mode_m_q, mode_s_q, mode_q;
    logic [WIDTH-1:0] stable, upd;
    logic             changed_q;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic             tick, entry;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] led_q, led_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m_q   <= '0;
            sw_s_q   <= '0;
            mode_m_q <= '0;
            mode_s_q <= '0;
        end else begin
            sw_m_q   <= switch;
            sw_s_q   <= sw_m_q;
            mode_m_q <= mode;
            mode_s_q <= mode_m_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        switch_led_db_lane #(.DEBOUNCE(DEBOUNCE)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_s   (sw_s_q[i]),
            .stable (stable[i]),
            .upd    (upd[i])
        );
    end

    assign tick    = (presc_q == PS_LAST);
    assign presc_d = tick ? '0 : presc_q + PS_W'(1);
    assign entry   = (mode_s_q != mode_q);

    // Priority entry > changed > tick; the new mode already acts in its entry cycle.
    always_comb begin
        led_d   = led_q;
        phase_d = phase_q;
        case (mode_s_q)
            2'd0: led_d = stable;
            2'd1: begin
                if (entry || changed_q) led_d = stable;
                else if (tick)          led_d = led_q + WIDTH'(1);
            end
            2'd2: begin
                if (entry)     led_d = WIDTH'(1);
                else if (tick) led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            end
            default: begin
                led_d = phase_q ? stable : '0;
                if (entry)     phase_d = 1'b1;
                else if (tick) phase_d = ~phase_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            changed_q <= 1'b0;
            presc_q   <= '0;
            phase_q   <= 1'b0;
            led_q     <= '0;
        end else begin
            mode_q    <= mode_s_q;
            changed_q <= |upd;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
        end
    end

    assign led       = led_q;
    assign sw_stable = stable;
    assign changed   = changed_q;
endmodule

// File: tb/tb_switch_led_ctrl.sv
// Scoreboarded bench for switch_led_ctrl: debounce latency, glitch reject,
// counter wrap/priority, chaser, blink and asynchronous reset.

module tb_switch_led_ctrl;
    localparam int W  = 6;
    localparam int DB = 4;
    localparam int TD = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] switch = '0;
    logic [1:0]   mode = '0;
    logic [W-1:0] led, sw_stable;
    logic         changed;

    switch_led_ctrl #(.WIDTH(W), .DEBOUNCE(DB), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .switch    (switch),
        .mode      (mode),
        .led       (led),
        .sw_stable (sw_stable),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = (tag_q.size() != 0) ? tag_q.pop_front() : "sb_underflow";
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk(t, obs, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for led to move; gap=0 means it never did within max cycles.
    task automatic wait_chg(input int max, output int gap);
        logic [W-1:0] prev;
        prev = led;
        gap  = 0;
        for (int i = 1; i <= max; i++) begin
            step(1);
            if (led != prev) begin
                gap = i;
                break;
            end
        end
    endtask

    task automatic glitch(input int n, output int pulses, output int hi);
        pulses = 0;
        hi     = 0;
        switch = 6'b000001;
        for (int i = 0; i < 20; i++) begin
            if (i == n) switch = '0;
            step(1);
            pulses += int'(changed);
            hi     += int'(sw_stable[0]);
        end
    endtask

    initial begin
        int gap, pulses, hi;
        logic [W-1:0] e;

        #2;
        push("rst_led", 0);     pop_chk(led);
        push("rst_stable", 0);  pop_chk(sw_stable);
        push("rst_changed", 0); pop_chk(changed);
        #20 rst_n = 1'b1;
        step(2);

        // Debounce latency: held level appears DB+2 edges later.
        switch = 6'b000101;
        push("deb_early", 0);
        step(5);
        pop_chk(sw_stable);
        push("deb_stable", 5); push("deb_chg", 1); push("deb_led_lag", 0);
        step(1);
        pop_chk(sw_stable); pop_chk(changed); pop_chk(led);
        push("deb_chg_end", 0); push("deb_led", 5);
        step(1);
        pop_chk(changed); pop_chk(led);

        switch = '0;
        push("deb_back", 0);
        step(10);
        pop_chk(sw_stable);

        // Glitch reject: DB-1 cycles is rejected, DB cycles gets through.
        push("glitch3_pulses", 0); push("glitch3_hi", 0);
        glitch(3, pulses, hi);
        pop_chk(pulses); pop_chk(hi);
        push("glitch4_pulses", 2); push("glitch4_hi", 4);
        glitch(4, pulses, hi);
        pop_chk(pulses); pop_chk(hi);

        // Counter: load, wrap, then changed beats a coincident tick.
        switch = 6'h3F;
        step(8);
        mode = 2'd1;
        push("cnt_entry", 6'h3F);
        step(3);
        pop_chk(led);
        push("cnt_wrap", 0);
        wait_chg(TD + 2, gap);
        pop_chk(led);
        push("cnt_one", 1); push("cnt_gap", TD);
        wait_chg(TD + 2, gap);
        pop_chk(led); pop_chk(gap);
        step(9);
        switch = 6'h0A;
        push("cnt_pre", 2); push("cnt_chg_pulse", 1);
        step(6);
        pop_chk(led); pop_chk(changed);
        push("cnt_changed", 6'h0A);
        step(1);
        pop_chk(led);
        push("cnt_after", 6'h0B); push("cnt_after_gap", TD);
        wait_chg(TD + 2, gap);
        pop_chk(led); pop_chk(gap);

        // Chaser: one-hot walk, MSB wraps to LSB on the 6th tick.
        mode = 2'd2;
        push("chase_entry", 1);
        step(3);
        pop_chk(led);
        for (int k = 1; k <= W; k++) begin
            e = W'(1) << (k % W);
            push($sformatf("chase_%0d", k), e);
            wait_chg(TD + 2, gap);
            pop_chk(led);
            if (k >= 2) begin
                push($sformatf("chase_gap_%0d", k), TD);
                pop_chk(gap);
            end
        end

        // Blink: entry forces phase on, then toggles every tick.
        switch = 6'h2A;
        step(8);
        mode = 2'd3;
        push("blink_entry", 6'h2A);
        step(4);
        pop_chk(led);
        push("blink_off", 0);
        wait_chg(TD + 2, gap);
        pop_chk(led);
        push("blink_on", 6'h2A); push("blink_gap_on", TD);
        wait_chg(TD + 2, gap);
        pop_chk(led); pop_chk(gap);
        push("blink_off2", 0); push("blink_gap_off", TD);
        wait_chg(TD + 2, gap);
        pop_chk(led); pop_chk(gap);

        // Async reset mid-count, between edges.
        mode = 2'd1;
        step(6);
        #2 rst_n = 1'b0;
        #1;
        push("arst_led", 0); push("arst_stable", 0); push("arst_changed", 0);
        pop_chk(led); pop_chk(sw_stable); pop_chk(changed);
        #10 rst_n = 1'b1;
        push("rel_entry_led", 0);
        step(3);
        pop_chk(led);
        push("rel_stable", 6'h2A); push("rel_chg", 1); push("rel_led_pre", 0);
        step(3);
        pop_chk(sw_stable); pop_chk(changed); pop_chk(led);
        push("rel_led_load", 6'h2A);
        step(1);
        pop_chk(led);
        push("rel_first_tick", 6'h2B);
        step(1);
        pop_chk(led);

        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
